// File: rtl/mycore_video_pkg.sv
// Shared raster geometry for the mycore video path, plus the timing bundle
// that travels with each pixel position.
package mycore_video_pkg;

    localparam int unsigned CE_DIV       = 8;
    localparam int unsigned H_ACTIVE     = 320;
    localparam int unsigned H_FP         = 8;
    localparam int unsigned H_SYNC       = 32;
    localparam int unsigned H_TOTAL      = 384;
    localparam int unsigned V_ACTIVE     = 240;
    localparam int unsigned V_TOTAL_NTSC = 262;
    localparam int unsigned V_TOTAL_PAL  = 312;
    localparam int unsigned V_SYNC_NTSC  = 244;
    localparam int unsigned V_SYNC_PAL   = 270;
    localparam int unsigned V_SYNC_LEN   = 3;

    typedef struct packed {
        logic [8:0] hcount;
        logic [8:0] vcount;
        logic       hblank;
        logic       hsync;
        logic       vblank;
        logic       vsync;
    } video_timing_t;

endpackage

// File: rtl/mycore_ce_div.sv
// Pixel-enable divider: one-clk strobe every DIV clocks, or every DIV/2 when half is set.
module mycore_ce_div #(
    parameter int unsigned DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic half,
    output logic ce
);

    localparam int unsigned W = $clog2(DIV);

    logic [W-1:0] div;
    logic [W-1:0] last;

    assign last = half ? W'(DIV / 2 - 1) : W'(DIV - 1);
    assign ce   = (div == last);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   div <= '0;
        else if (ce) div <= '0;
        else         div <= div + W'(1);
    end

endmodule

// File: rtl/mycore_video_timing.sv
// Raster timing generator: pixel enable, h/v counters and blank/sync strobes,
// with NTSC/PAL frame geometry and a 31 kHz line-doubled mode.
module mycore_video_timing #(
    parameter int unsigned CE_DIV       = mycore_video_pkg::CE_DIV,
    parameter int unsigned H_ACTIVE     = mycore_video_pkg::H_ACTIVE,
    parameter int unsigned H_FP         = mycore_video_pkg::H_FP,
    parameter int unsigned H_SYNC       = mycore_video_pkg::H_SYNC,
    parameter int unsigned H_TOTAL      = mycore_video_pkg::H_TOTAL,
    parameter int unsigned V_ACTIVE     = mycore_video_pkg::V_ACTIVE,
    parameter int unsigned V_TOTAL_NTSC = mycore_video_pkg::V_TOTAL_NTSC,
    parameter int unsigned V_TOTAL_PAL  = mycore_video_pkg::V_TOTAL_PAL,
    parameter int unsigned V_SYNC_NTSC  = mycore_video_pkg::V_SYNC_NTSC,
    parameter int unsigned V_SYNC_PAL   = mycore_video_pkg::V_SYNC_PAL,
    parameter int unsigned V_SYNC_LEN   = mycore_video_pkg::V_SYNC_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pal,
    input  logic       scandouble,
    output logic       ce_pix,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       HBlank,
    output logic       HSync,
    output logic       VBlank,
    output logic       VSync,
    output logic       new_frame
);

    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] HB_START = 9'(H_ACTIVE);
    localparam logic [8:0] HS_START = 9'(H_ACTIVE + H_FP);
    localparam logic [8:0] HS_END   = 9'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0] VB_START = 9'(V_ACTIVE);

    mycore_video_pkg::video_timing_t cur, nxt;

    logic       tick;
    logic       pal_l, sd_l, line_rep;
    logic       pal_n, line_end, v_step, frame_end;
    logic [8:0] v_last, vs_start, vs_end, h_n, v_n;

    mycore_ce_div #(.DIV(CE_DIV)) u_ce_div (
        .clk   (clk),
        .reset (reset),
        .half  (sd_l),
        .ce    (tick)
    );

    // NOTE: mode flops carry no reset value on purpose: they load the live inputs
    // on every edge while reset is held, and otherwise only at a frame boundary.
    always_ff @(posedge clk) begin
        if (reset || (tick && frame_end)) begin
            pal_l <= pal;
            sd_l  <= scandouble;
        end
    end

    // NOTE: every variable below gets a value on all paths, so no latch is inferred.
    always_comb begin
        line_end  = (cur.hcount == H_LAST);
        v_last    = pal_l ? 9'(V_TOTAL_PAL - 1) : 9'(V_TOTAL_NTSC - 1);
        v_step    = line_end && (!sd_l || line_rep);
        frame_end = v_step && (cur.vcount >= v_last);
        pal_n     = frame_end ? pal : pal_l;
        vs_start  = pal_n ? 9'(V_SYNC_PAL) : 9'(V_SYNC_NTSC);
        vs_end    = vs_start + 9'(V_SYNC_LEN);

        h_n = line_end ? 9'd0 : cur.hcount + 9'd1;
        if (frame_end)   v_n = 9'd0;
        else if (v_step) v_n = cur.vcount + 9'd1;
        else             v_n = cur.vcount;

        // Strobes decode the next position so they land on the same edge as the counters.
        nxt.hcount = h_n;
        nxt.vcount = v_n;
        nxt.hblank = (h_n >= HB_START);
        nxt.hsync  = (h_n >= HS_START) && (h_n < HS_END);
        nxt.vblank = (v_n >= VB_START);
        nxt.vsync  = (v_n >= vs_start) && (v_n < vs_end);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= '0;
            line_rep  <= 1'b0;
            ce_pix    <= 1'b0;
            new_frame <= 1'b0;
        end else begin
            ce_pix    <= tick;
            new_frame <= tick && frame_end;
            if (tick) begin
                cur <= nxt;
                if (line_end) line_rep <= sd_l ? ~line_rep : 1'b0;
            end
        end
    end

    assign hcount = cur.hcount;
    assign vcount = cur.vcount;
    assign HBlank = cur.hblank;
    assign HSync  = cur.hsync;
    assign VBlank = cur.vblank;
    assign VSync  = cur.vsync;

endmodule
